// File: rtl/bayer_demosaic_2x2.sv
// bayer_demosaic_2x2: raw Bayer stream to 24-bit RGB, one pixel out per
// accepted sample, 1-cycle latency. A 2x2 window (current, left, up,
// up-left) is formed from one line buffer plus two registers.
// Optional feature macro: DEMOSAIC_GREEN_AVG_EN. When defined, interior
// green is the rounded average of the two window greens; otherwise it is
// the green sitting in the current row (nearest neighbour).
module bayer_demosaic_2x2 #(
  parameter int width         = 320,
  parameter int height        = 240,
  parameter int bayer_pattern = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iValid,
  input  logic [7:0]  iData,
  output logic        oValid,
  output logic [23:0] oData,
  output logic        oDone
);

  localparam int XW = (width  > 1) ? $clog2(width)  : 1;
  localparam int YW = (height > 1) ? $clog2(height) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(width - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(height - 1);

  // Window slots are indexed by absolute parity {row[0], col[0]}. The red
  // site sits at index bayer_pattern, blue at its complement, and the two
  // greens at the indices differing from red in exactly one bit.
  localparam logic [1:0] R_IDX  = 2'(bayer_pattern);
  localparam logic [1:0] B_IDX  = ~R_IDX;
  localparam logic [1:0] GA_IDX = R_IDX ^ 2'b01;
  localparam logic [1:0] GB_IDX = R_IDX ^ 2'b10;

`ifdef DEMOSAIC_GREEN_AVG_EN
  function automatic logic [7:0] green_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b} + 9'd1;
    return sum[8:1];
  endfunction
`endif

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    left;
  logic [7:0]    upleft;
  logic [7:0]    line_mem [width];
  logic [7:0]    up;

  logic [1:0]    cur_par;
  logic [1:0]    ga_sel;
  logic [1:0]    gb_sel;
  logic [7:0]    win [4];
  logic [7:0]    r_val;
  logic [7:0]    g_val;
  logic [7:0]    b_val;
  logic [7:0]    ga_val;
  logic [7:0]    gb_val;
  logic [23:0]   rgb_p0;
  logic          done_p0;

  logic          vld_p1;
  logic [23:0]   rgb_p1;
  logic          done_p1;

  // Read-before-write: the pixel above is read at the same address
  // that this sample overwrites.
  assign up = line_mem[x];

  // Window interpolation and border handling for the accepted sample.
  always_comb begin
    cur_par = {y[0], x[0]};
    win[0]  = iData;
    win[1]  = left;
    win[2]  = up;
    win[3]  = upleft;
    ga_sel  = GA_IDX ^ cur_par;
    gb_sel  = GB_IDX ^ cur_par;
    r_val   = win[R_IDX ^ cur_par];
    b_val   = win[B_IDX ^ cur_par];
    ga_val  = win[ga_sel];
    gb_val  = win[gb_sel];
`ifdef DEMOSAIC_GREEN_AVG_EN
    g_val   = green_avg(ga_val, gb_val);
`else
    // Relative slot bit 1 clear means current or left, i.e. current row.
    g_val   = ga_sel[1] ? gb_val : ga_val;
`endif
    if (x == '0 || y == '0) rgb_p0 = {iData, iData, iData};
    else                    rgb_p0 = {r_val, g_val, b_val};
    done_p0 = (x == X_LAST) && (y == Y_LAST);
  end

  // Raster counters and the left/up-left window registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      left   <= '0;
      upleft <= '0;
    end else if (iValid) begin
      left   <= iData;
      upleft <= up;
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Line buffer write; contents are never consumed on row 0, so no reset.
  always_ff @(posedge clk) begin
    if (iValid) line_mem[x] <= iData;
  end

  // ---- stage p0 -> p1: registered outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      rgb_p1  <= '0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= iValid;
      done_p1 <= iValid & done_p0;
      if (iValid) rgb_p1 <= rgb_p0;
    end
  end

  assign oValid = vld_p1;
  assign oData  = rgb_p1;
  assign oDone  = done_p1;

endmodule
